// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: run/halt/step control around a 0..PHASES-1 phase
// counter with per-instruction terminal phase, stall input and one-hot decode.
module phase_sequencer #(
  parameter int PHASES = 10,
  parameter int LOG    = 0
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       run,
  input  logic       _wait,
  input  logic       step_req,
  input  logic [3:0] last_phase,
  output logic [3:0] phase,
  output logic [9:0] q,
  output logic       _co,
  output logic       eot,
  output logic       step_ack,
  output logic       halted
);

  localparam logic [1:0] S_HALT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;

  localparam logic [3:0] MAX_PHASE = 4'(PHASES - 1);

  // Out-of-range sizing stops elaboration; LOG only selects tracing in simulation.
  if (PHASES < 2 || PHASES > 10 || LOG < 0) begin : g_bad_param
    $error("phase_sequencer: PHASES must be 2..10 and LOG non-negative");
  end

  logic [1:0] state, state_next;
  logic [3:0] term;
  logic [3:0] phase_next;
  logic [3:0] clamped_last;
  logic [3:0] eterm;
  logic       adv;

  // The terminal phase is sampled live at phase 0, then held for the instruction.
  assign clamped_last = (last_phase > MAX_PHASE) ? MAX_PHASE : last_phase;
  assign eterm        = (phase == 4'd0) ? clamped_last : term;
  assign adv          = ((state == S_RUN) || (state == S_STEP)) && _wait;
  assign eot          = adv && (phase == eterm);

  assign halted = (state == S_HALT);
  assign q      = 10'b1 << phase;
  assign _co    = (phase <= 4'd4);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    phase_next = phase;
    unique case (state)
      S_HALT: begin
        phase_next = 4'd0;
        if (run)           state_next = S_RUN;
        else if (step_req) state_next = S_STEP;
      end
      S_RUN: begin
        if (eot && !run) state_next = S_HALT;
      end
      S_STEP: begin
        if (eot) state_next = S_HALT;
      end
      default: begin
        state_next = S_HALT;
        phase_next = 4'd0;
      end
    endcase
    if (adv) phase_next = eot ? 4'd0 : phase + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (mr) begin
      state    <= S_HALT;
      phase    <= 4'd0;
      term     <= MAX_PHASE;
      step_ack <= 1'b0;
    end else begin
      state    <= state_next;
      phase    <= phase_next;
      step_ack <= (state == S_STEP) && eot;
      if (adv && (phase == 4'd0)) term <= eterm;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a 10-phase instance for run/stall/halt/step
// and a 6-phase instance for terminal clamping and reset during a step.
module tb_phase_sequencer;

  localparam int LOG = 0;

  logic       clk = 1'b0;
  logic       mr, run, wait_n, step_req;
  logic [3:0] last_phase;
  logic [3:0] phase;
  logic [9:0] q;
  logic       co, eot, step_ack, halted;

  logic       mr6, run6, wait6_n, step_req6;
  logic [3:0] last_phase6;
  logic [3:0] phase6;
  logic [9:0] q6;
  logic       co6, eot6, step_ack6, halted6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.PHASES(10), .LOG(LOG)) dut (
    .clk(clk), .mr(mr), .run(run), ._wait(wait_n), .step_req(step_req),
    .last_phase(last_phase), .phase(phase), .q(q), ._co(co), .eot(eot),
    .step_ack(step_ack), .halted(halted)
  );

  phase_sequencer #(.PHASES(6), .LOG(LOG)) dut6 (
    .clk(clk), .mr(mr6), .run(run6), ._wait(wait6_n), .step_req(step_req6),
    .last_phase(last_phase6), .phase(phase6), .q(q6), ._co(co6), .eot(eot6),
    .step_ack(step_ack6), .halted(halted6)
  );

  if (LOG != 0) begin : g_trace
    always @(negedge clk)
      $display("t=%0t halted=%b phase=%0d q=%03h co=%b eot=%b ack=%b", $time,
               halted, phase, q, co, eot, step_ack);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect10(input string tag, input int ph, input bit e_eot, input bit e_halt);
    check({tag, ".phase"}, 32'(phase), 32'(ph));
    check({tag, ".q"}, 32'(q), 32'(1) << ph);
    check({tag, ".co"}, 32'(co), 32'(ph <= 4));
    check({tag, ".eot"}, 32'(eot), 32'(e_eot));
    check({tag, ".halted"}, 32'(halted), 32'(e_halt));
  endtask

  task automatic expect6(input string tag, input int ph, input bit e_eot, input bit e_halt);
    check({tag, ".phase"}, 32'(phase6), 32'(ph));
    check({tag, ".q"}, 32'(q6), 32'(1) << ph);
    check({tag, ".co"}, 32'(co6), 32'(ph <= 4));
    check({tag, ".eot"}, 32'(eot6), 32'(e_eot));
    check({tag, ".halted"}, 32'(halted6), 32'(e_halt));
  endtask

  initial begin
    mr = 1'b1; run = 1'b0; wait_n = 1'b1; step_req = 1'b0; last_phase = 4'd9;
    mr6 = 1'b1; run6 = 1'b0; wait6_n = 1'b1; step_req6 = 1'b0; last_phase6 = 4'd12;

    // Reset, then free run of a full 10-phase instruction
    repeat (2) tick();
    expect10("reset", 0, 0, 1);
    check("reset.ack", 32'(step_ack), 32'd0);
    mr = 1'b0; run = 1'b1;
    tick();
    expect10("run_start", 0, 0, 0);
    for (int p = 1; p <= 9; p++) begin
      tick();
      expect10($sformatf("run_p%0d", p), p, p == 9, 0);
    end
    tick();
    expect10("run_wrap", 0, 0, 0);

    // Short instruction: terminal 3 latched at phase 0, later change ignored
    last_phase = 4'd3; #1;
    expect10("short_p0", 0, 0, 0);
    tick(); last_phase = 4'd7; #1;
    expect10("short_p1", 1, 0, 0);
    tick(); expect10("short_p2", 2, 0, 0);
    tick(); expect10("short_p3", 3, 1, 0);
    tick(); expect10("short_wrap", 0, 0, 0);

    // Stall three cycles at phase 4
    last_phase = 4'd9;
    repeat (4) tick();
    expect10("stall_pre", 4, 0, 0);
    wait_n = 1'b0; #1;
    expect10("stall_in", 4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect10($sformatf("stall_h%0d", i), 4, 0, 0);
    end
    wait_n = 1'b1;
    tick(); expect10("stall_resume", 5, 0, 0);
    repeat (4) tick();
    expect10("stall_p9", 9, 1, 0);
    tick(); expect10("stall_wrap", 0, 0, 0);

    // Halt at boundary: run drops at phase 2, instruction still completes
    last_phase = 4'd6;
    tick(); tick();
    expect10("halt_p2", 2, 0, 0);
    run = 1'b0;
    for (int p = 3; p <= 6; p++) begin
      tick();
      expect10($sformatf("halt_p%0d", p), p, p == 6, 0);
    end
    tick(); expect10("halt_enter", 0, 0, 1);
    repeat (2) tick();
    expect10("halt_hold", 0, 0, 1);

    // Single step of a 5-phase instruction; extra step_req during STEP ignored
    step_req = 1'b1; last_phase = 4'd4; #1;
    expect10("step_req", 0, 0, 1);
    tick(); expect10("step_p0", 0, 0, 0);
    step_req = 1'b0;
    tick(); expect10("step_p1", 1, 0, 0);
    step_req = 1'b1;
    tick(); expect10("step_p2", 2, 0, 0);
    step_req = 1'b0;
    tick(); expect10("step_p3", 3, 0, 0);
    check("step_p3.ack", 32'(step_ack), 32'd0);
    tick(); expect10("step_p4", 4, 1, 0);
    tick(); expect10("step_done", 0, 0, 1);
    check("step_done.ack", 32'(step_ack), 32'd1);
    tick(); expect10("step_after", 0, 0, 1);
    check("step_after.ack", 32'(step_ack), 32'd0);

    // PHASES=6: terminal 12 clamps to 5
    mr6 = 1'b0; step_req6 = 1'b1; #1;
    expect6("c6_reset", 0, 0, 1);
    tick(); expect6("c6_p0", 0, 0, 0);
    step_req6 = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      tick();
      expect6($sformatf("c6_p%0d", p), p, p == 5, 0);
    end
    tick(); expect6("c6_done", 0, 0, 1);
    check("c6_done.ack", 32'(step_ack6), 32'd1);

    // Reset at phase 3 of a step: back to HALT, no acknowledge
    step_req6 = 1'b1;
    tick(); expect6("c6_s2_p0", 0, 0, 0);
    check("c6_s2_p0.ack", 32'(step_ack6), 32'd0);
    step_req6 = 1'b0;
    repeat (3) tick();
    expect6("c6_s2_p3", 3, 0, 0);
    mr6 = 1'b1;
    tick(); expect6("c6_mr", 0, 0, 1);
    check("c6_mr.ack", 32'(step_ack6), 32'd0);
    mr6 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect6($sformatf("c6_idle%0d", i), 0, 0, 1);
      check($sformatf("c6_idle%0d.ack", i), 32'(step_ack6), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
